// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store stage,
// with one outstanding transaction at a time; data requests always win over fetches.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    RESP_I = 3'd2,
    REQ_D  = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t state;
  logic   kill_pend;

  // Memory handshake: a request transfers on a cycle with mem_valid & mem_ready; the payload
  // stays stable while mem_valid is high and not yet accepted; the single response arrives
  // later as a one-cycle mem_rvalid and is only honoured in the matching RESP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill_pend <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill_pend <= 1'b0;
          if (d_req) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_we ? d_wstrb : '0;
            mem_valid <= 1'b1;
            state     <= REQ_D;
          end else if (if_req && !if_kill) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wstrb <= '0;
            mem_valid <= 1'b1;
            state     <= REQ_I;
          end
        end
        REQ_I: begin
          if (if_kill) kill_pend <= 1'b1;
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP_I;
          end
        end
        RESP_I: begin
          // A killed fetch still drains its memory response; only the return is swallowed.
          if (mem_rvalid) begin
            kill_pend <= 1'b0;
            state     <= IDLE;
          end else if (if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        REQ_D: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP_D;
          end
        end
        RESP_D: begin
          if (mem_rvalid) begin
            kill_pend <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign if_rvalid = (state == RESP_I) && mem_rvalid && !kill_pend && !if_kill;
  assign d_rvalid  = (state == RESP_D) && mem_rvalid;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign stall_if  = if_req && !if_rvalid;
  assign stall_mem = d_req && !d_rvalid;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both pipeline stages and the memory,
// cycle by cycle, and compares outputs against hand-computed values at the falling edge.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_req = 1'b0;
  logic [AW-1:0]   if_addr = '0;
  logic            if_kill = 1'b0;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic [DW/8-1:0] d_wstrb = '0;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            stall_if;
  logic            stall_mem;
  logic            mem_valid;
  logic            mem_ready = 1'b0;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_rvalid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic [2:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ_I = 3'd1;
  localparam logic [2:0] S_RESP_I = 3'd2;
  localparam logic [2:0] S_REQ_D = 3'd3;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    sample();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid: got %b exp 0", if_rvalid); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid: got %b exp 0", d_rvalid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    checks++; if ({mem_we, mem_wstrb} !== 5'b0) begin errors++; $display("FAIL reset_we_wstrb: got %b exp 0", {mem_we, mem_wstrb}); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_wdata); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_dbg); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_stray_response();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    sample();
    checks++; if ({mem_valid, if_rvalid, d_rvalid, stall_if, stall_mem} !== 5'b0) begin errors++; $display("FAIL stray_outputs: got %b exp 00000", {mem_valid, if_rvalid, d_rvalid, stall_if, stall_mem}); end
    next_cycle();
    mem_rvalid = 1'b0;
    sample();
    checks++; if (state_dbg !== S_IDLE || mem_valid !== 1'b0) begin errors++; $display("FAIL stray_state: got %0d/%b exp 0/0", state_dbg, mem_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL stray_mem_addr: got %h exp 0", mem_addr); end
    next_cycle();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    sample();
    checks++; if (mem_valid !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_c0: got valid=%b stall=%b exp 0/1", mem_valid, stall_if); end
    next_cycle();
    mem_ready = 1'b1;
    sample();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_req: got v=%b a=%h we=%b exp 1/40/0", mem_valid, mem_addr, mem_we); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL fetch_wstrb: got %h exp 0", mem_wstrb); end
    next_cycle();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0013;
    sample();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_drop: got %b exp 0", mem_valid); end
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_resp: got %b/%h exp 1/13", if_rvalid, if_rdata); end
    checks++; if (stall_if !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_stall: got stall=%b drv=%b exp 0/0", stall_if, d_rvalid); end
    next_cycle();
    if_req = 1'b0;
    mem_rvalid = 1'b0;
    sample();
    checks++; if (state_dbg !== S_IDLE || mem_valid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_done: got s=%0d v=%b rv=%b exp 0/0/0", state_dbg, mem_valid, if_rvalid); end
    next_cycle();
  endtask

  task automatic test_collision();
    if_req = 1'b1;
    if_addr = 32'h0000_0080;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h0000_0100;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'b1111;
    sample();
    checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL coll_stalls: got %b%b exp 11", stall_if, stall_mem); end
    next_cycle();
    mem_ready = 1'b1;
    sample();
    checks++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL coll_d_first: got v=%b we=%b a=%h exp 1/1/100", mem_valid, mem_we, mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin errors++; $display("FAIL coll_payload: got %h/%h exp deadbeef/f", mem_wdata, mem_wstrb); end
    next_cycle();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0000;
    sample();
    checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("FAIL coll_d_resp: got d=%b i=%b exp 1/0", d_rvalid, if_rvalid); end
    checks++; if (stall_mem !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL coll_resp_stalls: got mem=%b if=%b exp 0/1", stall_mem, stall_if); end
    next_cycle();
    d_req = 1'b0;
    mem_rvalid = 1'b0;
    sample();
    checks++; if (mem_valid !== 1'b0 || state_dbg !== S_IDLE || stall_if !== 1'b1) begin errors++; $display("FAIL coll_idle_gap: got v=%b s=%0d st=%b exp 0/0/1", mem_valid, state_dbg, stall_if); end
    next_cycle();
    mem_ready = 1'b1;
    sample();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL coll_if_req: got v=%b a=%h we=%b ws=%h exp 1/80/0/0", mem_valid, mem_addr, mem_we, mem_wstrb); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL coll_if_stall: got %b exp 1", stall_if); end
    next_cycle();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_1234;
    sample();
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234) begin errors++; $display("FAIL coll_if_resp: got %b/%h exp 1/1234", if_rvalid, if_rdata); end
    next_cycle();
    if_req = 1'b0;
    mem_rvalid = 1'b0;
    next_cycle();
  endtask

  task automatic test_backpressure();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h0000_0300;
    d_wdata = 32'h1111_2222;
    d_wstrb = 4'b0011;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      mem_rvalid = (i == 2);  // stray response while the request is still pending
      mem_rdata = 32'hBAD0_0000;
      sample();
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL bp_hold_%0d: got v=%b a=%h exp 1/300", i, mem_valid, mem_addr); end
      checks++; if (mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL bp_wstrb_%0d: got ws=%h we=%b exp 0/0", i, mem_wstrb, mem_we); end
      checks++; if (d_rvalid !== 1'b0 || stall_mem !== 1'b1) begin errors++; $display("FAIL bp_no_resp_%0d: got rv=%b st=%b exp 0/1", i, d_rvalid, stall_mem); end
      next_cycle();
    end
    mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    sample();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL bp_accept: got v=%b a=%h exp 1/300", mem_valid, mem_addr); end
    next_cycle();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_CAFE;
    sample();
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE || mem_valid !== 1'b0) begin errors++; $display("FAIL bp_resp: got rv=%b d=%h v=%b exp 1/cafe/0", d_rvalid, d_rdata, mem_valid); end
    next_cycle();
    d_req = 1'b0;
    mem_rvalid = 1'b0;
    next_cycle();
  endtask

  task automatic test_kill();
    if_req = 1'b1;
    if_kill = 1'b1;
    if_addr = 32'h0000_0180;
    next_cycle();
    if_kill = 1'b0;
    if_req = 1'b0;
    sample();
    checks++; if (mem_valid !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL kill_idle_block: got v=%b s=%0d exp 0/0", mem_valid, state_dbg); end
    next_cycle();
    if_req = 1'b1;
    next_cycle();
    mem_ready = 1'b1;
    sample();
    checks++; if (state_dbg !== S_REQ_I || mem_addr !== 32'h180) begin errors++; $display("FAIL kill_req: got s=%0d a=%h exp 1/180", state_dbg, mem_addr); end
    next_cycle();
    mem_ready = 1'b0;
    if_kill = 1'b1;
    sample();
    checks++; if (state_dbg !== S_RESP_I || if_rvalid !== 1'b0) begin errors++; $display("FAIL kill_resp_wait: got s=%0d rv=%b exp 2/0", state_dbg, if_rvalid); end
    next_cycle();
    if_kill = 1'b0;
    if_req = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0099;
    sample();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL kill_swallow: got %b exp 0", if_rvalid); end
    next_cycle();
    mem_rvalid = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h0000_0200;
    sample();
    checks++; if (state_dbg !== S_IDLE || mem_valid !== 1'b0) begin errors++; $display("FAIL kill_back_idle: got s=%0d v=%b exp 0/0", state_dbg, mem_valid); end
    next_cycle();
    mem_ready = 1'b1;
    sample();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL kill_new_req: got v=%b a=%h exp 1/200", mem_valid, mem_addr); end
    next_cycle();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0055;
    sample();
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55) begin errors++; $display("FAIL kill_new_resp: got %b/%h exp 1/55", if_rvalid, if_rdata); end
    next_cycle();
    if_req = 1'b0;
    mem_rvalid = 1'b0;
    next_cycle();
  endtask

  task automatic test_async_reset();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h0000_0400;
    d_wdata = 32'h0BAD_F00D;
    d_wstrb = 4'b0101;
    next_cycle();
    sample();
    checks++; if (mem_valid !== 1'b1 || state_dbg !== S_REQ_D) begin errors++; $display("FAIL arst_pre: got v=%b s=%0d exp 1/3", mem_valid, state_dbg); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || state_dbg !== S_IDLE || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_immediate: got v=%b s=%0d a=%h exp 0/0/0", mem_valid, state_dbg, mem_addr); end
    d_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    sample();
    checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL arst_late_resp: got d=%b i=%b v=%b exp 0/0/0", d_rvalid, if_rvalid, mem_valid); end
    next_cycle();
    mem_rvalid = 1'b0;
    sample();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL arst_state: got %0d exp 0", state_dbg); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stray_response();
    test_single_fetch();
    test_collision();
    test_backpressure();
    test_kill();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (IF, read-only) and the memory stage (MEM, load/store).
- Decides the winner at each idle cycle. Holds exactly one outstanding memory transaction at a time.
- Returns each response to its requester and drives the stall signals the pipeline hazard logic consumes.
- Sits between the IF/MEM pipeline stages and the memory wrapper.

Parameters:
AW, 32, address width
DW, 32, data width (byte strobe width is DW/8)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_rvalid or if_kill
if_addr  in  AW  fetch address
if_kill  in  1  one-cycle pulse: discard the pending fetch (branch/jump redirect)
if_rvalid  out  1  fetch data valid, one cycle
if_rdata  out  DW  fetched instruction
d_req  in  1  data request; held high until d_rvalid
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_wstrb  in  DW/8  store byte enables
d_rvalid  out  1  data response, one cycle (load data or store ack)
d_rdata  out  DW  load data
stall_if  out  1  fetch stage must hold
stall_mem  out  1  memory stage must hold
mem_valid  out  1  request to memory
mem_ready  in  1  memory accepts the request
mem_we  out  1  write enable
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_wstrb  out  DW/8  byte enables; 0 for reads
mem_rvalid  in  1  response from memory (reads and writes)
mem_rdata  in  DW  read data

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, kill_pend=0; mem_valid, if_rvalid, d_rvalid = 0; all registered mem_* payload = 0.
- Reset mid-transaction abandons the transaction. A late mem_rvalid after reset arrives in IDLE and is ignored.
- FSM states: IDLE, REQ_I, RESP_I, REQ_D, RESP_D.
- IDLE:
  - d_req=1 → latch d_addr/d_wdata/d_wstrb/d_we into the hold registers; go to REQ_D.
  - else if_req=1 and if_kill=0 → latch if_addr, set we=0, wstrb=0; go to REQ_I.
  - else stay in IDLE.
  - Data always wins because it belongs to the older instruction.
- REQ_x: mem_valid=1 with the held payload, which is stable until accepted. If mem_ready=1 → RESP_x the next cycle.
- RESP_x: mem_valid=0. If mem_rvalid=1 → return to IDLE the next cycle.
  - In RESP_D: d_rvalid = mem_rvalid and d_rdata = mem_rdata, both combinational pass-through.
  - In RESP_I: if_rvalid = mem_rvalid & ~kill_pend & ~if_kill, with if_rdata = mem_rdata.
- Minimum latency, request to response: 3 cycles (cycle 0 arbitrate, cycle 1 REQ with mem_ready=1, cycle 2 mem_rvalid). Every transaction is followed by one IDLE cycle before the next arbitration.
- kill_pend:
  - Set when if_kill=1 in REQ_I or RESP_I.
  - Cleared on entry to IDLE.
  - A killed fetch still completes on the memory side; it is never cancelled mid-handshake. Its response is swallowed (if_rvalid stays 0).
  - if_kill in IDLE blocks that cycle's IF arbitration.
- Stall outputs:
  - stall_if = if_req & ~if_rvalid.
  - stall_mem = d_req & ~d_rvalid.
- mem_rvalid in IDLE or REQ_x is a protocol violation. It is ignored, and no output responds to it.
- Simultaneous if_req and d_req in IDLE: D is granted; IF waits at least through the D transaction plus one IDLE cycle.
- Outputs that are not active are driven as: if_rdata/d_rdata = mem_rdata (only meaningful with their valid); mem_* = hold registers.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ready=1 at once, mem_rvalid one cycle later with rdata=0x0000_0013 → mem_valid high for exactly 1 cycle with mem_addr=0x40 and mem_we=0; if_rvalid=1 with if_rdata=0x13 in cycle 2; stall_if falls in that cycle.
- Collision: if_req and d_req (store, addr 0x100, wdata 0xDEADBEEF, wstrb 4'b1111) both rise in the same cycle → the first mem_valid carries we=1, addr=0x100; d_rvalid occurs first; the IF mem_valid starts exactly 2 cycles after d_rvalid; stall_if stays high throughout.
- Backpressure: mem_ready held low 4 cycles during a load with wstrb input 4'b0011 → mem_valid high 5 cycles with constant addr; mem_wstrb=0; no response before acceptance.
- Kill: pulse if_kill in RESP_I before mem_rvalid → memory still completes the read; if_rvalid stays 0; FSM returns to IDLE; a new if_req to 0x200 is then served normally.
- Async reset: assert rst_n=0 in REQ_D between clock edges → mem_valid drops immediately; state IDLE. A mem_rvalid pulse after release produces no d_rvalid or if_rvalid.
- Stray response: mem_rvalid=1 in IDLE with no requests → all outputs stay at reset values.
